// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and preset validation for the BCD stopwatch/timer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;
    // Index 5 = hour tens ... index 0 = second units.
    typedef bcd_t [5:0] bcd_time_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    function automatic logic bcd_time_valid(input bcd_time_t t, input int unsigned hours_max);
        logic        ok;
        int unsigned hours;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i] > DIGIT_MAX) begin
                ok = 1'b0;
            end
        end
        if (t[1] > SEC_TENS_MAX) begin
            ok = 1'b0;
        end
        if (t[3] > MIN_TENS_MAX) begin
            ok = 1'b0;
        end
        hours = 32'(t[5]) * 32'd10 + 32'(t[4]);
        if (hours > hours_max) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit step: next value plus carry (up) or borrow (down) to the next digit.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic en_i,
    input  logic dir_i,
    input  bcd_t digit_i,
    output bcd_t digit_o,
    output logic carry_o
);

    // Step the digit; wrap at 0/MAX and flag the ripple to the next digit.
    always_comb begin
        digit_o = digit_i;
        carry_o = 1'b0;
        if (en_i) begin
            if (dir_i) begin
                if (digit_i == 4'd0) begin
                    digit_o = MAX;
                    carry_o = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end else begin
                if (digit_i == MAX) begin
                    digit_o = 4'd0;
                    carry_o = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_timer.sv
// BCD stopwatch / countdown timer on a 1 Hz clock with wrap or saturate at HOURS_MAX:59:59.
// Optional lap register enabled by macro LAP_CAPTURE_EN.
module bcd_stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned HOURS_MAX = 99,
    parameter bit          WRAP_EN   = 1'b1
) (
    input  logic        CLK_1HZ,
    input  logic        RESET,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic        mode_down,
    input  logic [23:0] preset_bcd,
    input  logic        lap,
    output logic [23:0] time_bcd,
    output logic [23:0] lap_bcd,
    output logic        running,
    output logic        done,
    output logic        overflow,
    output logic        load_err
);

    localparam bcd_t      HR1_MAX   = bcd_t'(HOURS_MAX / 32'd10);
    localparam bcd_t      HR0_MAX   = bcd_t'(HOURS_MAX % 32'd10);
    localparam bcd_time_t TIME_ZERO = 24'h000000;
    localparam bcd_time_t LIMIT     = {HR1_MAX, HR0_MAX, MIN_TENS_MAX, DIGIT_MAX,
                                       SEC_TENS_MAX, DIGIT_MAX};

    state_t    state_q, state_d;
    bcd_time_t time_q, time_d;
    logic      mode_down_q, mode_down_d;
    logic      overflow_q, overflow_d;
    logic      load_err_q, load_err_d;

    logic [4:0] en_s;
    bcd_t       lo_nxt_s [0:3];
    bcd_t       hr1_nxt_s, hr0_nxt_s;
    bcd_time_t  tick_time_s;

    assign en_s[0] = 1'b1;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        localparam bcd_t D_MAX = (i == 1) ? SEC_TENS_MAX :
                                 (i == 3) ? MIN_TENS_MAX : DIGIT_MAX;
        bcd_digit_counter #(.MAX(D_MAX)) u_digit (
            .en_i    (en_s[i]),
            .dir_i   (mode_down_q),
            .digit_i (time_q[i]),
            .digit_o (lo_nxt_s[i]),
            .carry_o (en_s[i+1])
        );
    end

    // Hour pair: bounded by HOURS_MAX rather than a plain 00..99 BCD range.
    always_comb begin
        hr1_nxt_s = time_q[5];
        hr0_nxt_s = time_q[4];
        if (en_s[4]) begin
            if (mode_down_q) begin
                if (time_q[5] == 4'd0 && time_q[4] == 4'd0) begin
                    hr1_nxt_s = HR1_MAX;
                    hr0_nxt_s = HR0_MAX;
                end else if (time_q[4] == 4'd0) begin
                    hr1_nxt_s = time_q[5] - 4'd1;
                    hr0_nxt_s = DIGIT_MAX;
                end else begin
                    hr0_nxt_s = time_q[4] - 4'd1;
                end
            end else begin
                if (time_q[5] == HR1_MAX && time_q[4] == HR0_MAX) begin
                    hr1_nxt_s = 4'd0;
                    hr0_nxt_s = 4'd0;
                end else if (time_q[4] == DIGIT_MAX) begin
                    hr1_nxt_s = time_q[5] + 4'd1;
                    hr0_nxt_s = 4'd0;
                end else begin
                    hr0_nxt_s = time_q[4] + 4'd1;
                end
            end
        end else begin
            hr1_nxt_s = time_q[5];
        end
    end

    assign tick_time_s = {hr1_nxt_s, hr0_nxt_s, lo_nxt_s[3], lo_nxt_s[2], lo_nxt_s[1], lo_nxt_s[0]};

    // Command arbitration (clear > load > stop > start) and per-state behaviour.
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        mode_down_d = mode_down_q;
        overflow_d  = 1'b0;
        load_err_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            time_d  = TIME_ZERO;
        end else if (load && state_q != RUN) begin
            // A rejected load still consumes the edge: no stop/start action.
            if (bcd_time_valid(preset_bcd, HOURS_MAX)) begin
                time_d  = preset_bcd;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start) begin
                        mode_down_d = mode_down;
                        state_d     = (mode_down && time_q == TIME_ZERO) ? DONE : RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (mode_down_q) begin
                        time_d = tick_time_s;
                        if (tick_time_s == TIME_ZERO) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (time_q == LIMIT) begin
                        if (WRAP_EN) begin
                            time_d     = tick_time_s;
                            overflow_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        time_d = tick_time_s;
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, time and pulse registers.
    always_ff @(posedge CLK_1HZ or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            time_q      <= TIME_ZERO;
            mode_down_q <= 1'b0;
            overflow_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            mode_down_q <= mode_down_d;
            overflow_q  <= overflow_d;
            load_err_q  <= load_err_d;
        end
    end

`ifdef LAP_CAPTURE_EN
    bcd_time_t lap_q, lap_d;

    // Capture the pre-tick time while running; clear suppresses the capture.
    always_comb begin
        lap_d = lap_q;
        if (lap && !clear && state_q == RUN) begin
            lap_d = time_q;
        end else begin
            lap_d = lap_q;
        end
    end

    // Lap register.
    always_ff @(posedge CLK_1HZ or posedge RESET) begin
        if (RESET) begin
            lap_q <= TIME_ZERO;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign lap_bcd = lap_q;
`else
    logic unused_lap_s;
    assign unused_lap_s = lap;
    assign lap_bcd      = 24'h000000;
`endif

    assign time_bcd = time_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;
    assign load_err = load_err_q;

endmodule
